// File: rtl/aer_out_transmitter_pkg.sv
// Shared definitions for the AER output transmitter: link word width and FSM encodings.
package aer_out_transmitter_pkg;

   localparam int unsigned POST_NEUR_ADDR_WIDTH = 10;
   localparam int unsigned VIRTS_WIDTH          = 2;

   // AER word is the virts tag prepended to the neuron address
   function automatic int unsigned aer_word_width(input int unsigned addr_width);
      return VIRTS_WIDTH + addr_width;
   endfunction

   localparam int unsigned AER_OUT_WIDTH = aer_word_width(POST_NEUR_ADDR_WIDTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      REQ_HI = 2'd2,
      REQ_LO = 2'd3
   } aerout_state_e;

endpackage

// File: rtl/aer_out_transmitter_if.sv
// Core-side event push and off-chip AER link signals of the output transmitter.
// slave: transmitter view; master: core + receiver view.
interface aer_out_transmitter_if;
   import aer_out_transmitter_pkg::*;

   logic                            CORE_EVENT_IN;
   logic [VIRTS_WIDTH-1:0]          CORE_EVENT_VIRTS;
   logic [POST_NEUR_ADDR_WIDTH-1:0] CORE_EVENT_ADDR;
   logic                            SPI_AER_OUT_EN;
   logic                            AEROUT_ACK;
   logic                            AEROUT_REQ;
   logic [AER_OUT_WIDTH-1:0]        AEROUT_ADDR;
   logic                            AEROUT_FULL;
   logic                            AEROUT_EMPTY;
   logic                            AEROUT_DROP;
   logic                            AEROUT_TIMEOUT;

   modport slave (
      input  CORE_EVENT_IN, CORE_EVENT_VIRTS, CORE_EVENT_ADDR, SPI_AER_OUT_EN, AEROUT_ACK,
      output AEROUT_REQ, AEROUT_ADDR, AEROUT_FULL, AEROUT_EMPTY, AEROUT_DROP, AEROUT_TIMEOUT
   );

   modport master (
      output CORE_EVENT_IN, CORE_EVENT_VIRTS, CORE_EVENT_ADDR, SPI_AER_OUT_EN, AEROUT_ACK,
      input  AEROUT_REQ, AEROUT_ADDR, AEROUT_FULL, AEROUT_EMPTY, AEROUT_DROP, AEROUT_TIMEOUT
   );

endinterface

// File: rtl/aer_out_transmitter_fifo.sv
// Event buffer: synchronous FIFO with an extra pointer bit to tell full from empty.
// Caller must not write when full (unless reading) nor read when empty.
module aer_out_transmitter_fifo #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned DEPTH = 8
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage array, no reset needed: pointers define validity
   always_ff @(posedge CLK) begin
      if (wr_en) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
   end

   // Read/write pointers wrap modulo 2*DEPTH
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      end
   end

   assign rd_data = mem_q[rd_ptr_q[PTR_W-1:0]];
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

endmodule

// File: rtl/aer_out_transmitter.sv
// AER output transmitter: buffers core spike events and serialises them over a 4-phase
// REQ/ACK link. Optional per-phase handshake timeout enabled by defining AEROUT_TIMEOUT_EN.
module aer_out_transmitter
   import aer_out_transmitter_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   aer_out_transmitter_if.slave  bus
);

   logic                     ack_meta_q, ack_s;
   logic                     en_meta_q, en_s;
   logic                     fifo_full, fifo_empty;
   logic [AER_OUT_WIDTH-1:0] fifo_rd_data;
   logic                     push_req, push, pop, drop_set;
   aerout_state_e            state_q, state_d;
   logic                     req_q, req_d;
   logic [AER_OUT_WIDTH-1:0] addr_q, addr_d;
   logic                     drop_q, timeout_q;
   logic                     phase_timeout, abort;

   // Two-flop synchronisers for the asynchronous ACK and enable inputs
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         ack_meta_q <= 1'b0;
         ack_s      <= 1'b0;
         en_meta_q  <= 1'b0;
         en_s       <= 1'b0;
      end else begin
         ack_meta_q <= bus.AEROUT_ACK;
         ack_s      <= ack_meta_q;
         en_meta_q  <= bus.SPI_AER_OUT_EN;
         en_s       <= en_meta_q;
      end
   end

   // A pop frees a slot in the same cycle, so a push while full is still accepted then
   assign push_req = bus.CORE_EVENT_IN & en_s;
   assign push     = push_req & (~fifo_full | pop);
   assign drop_set = push_req & fifo_full & ~pop;

   aer_out_transmitter_fifo #(
      .WIDTH (AER_OUT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RSTN    (RSTN),
      .wr_en   (push),
      .wr_data ({bus.CORE_EVENT_VIRTS, bus.CORE_EVENT_ADDR}),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

`ifdef AEROUT_TIMEOUT_EN
   localparam int unsigned CNT_WIDTH = $clog2(ACK_TIMEOUT + 1);

   logic [CNT_WIDTH-1:0] phase_cnt_q, phase_cnt_d;

   // Phase counter restarts on every state change and only runs while waiting on ACK
   always_comb begin
      phase_cnt_d = phase_cnt_q;
      if (state_d != state_q) begin
         phase_cnt_d = '0;
      end else if ((state_q == REQ_HI) || (state_q == REQ_LO)) begin
         phase_cnt_d = phase_cnt_q + CNT_WIDTH'(1);
      end
   end

   // Phase counter register
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) phase_cnt_q <= '0;
      else       phase_cnt_q <= phase_cnt_d;
   end

   assign phase_timeout = (phase_cnt_q == CNT_WIDTH'(ACK_TIMEOUT));
`else
   logic unused_ack_timeout;
   assign unused_ack_timeout = |ACK_TIMEOUT;
   assign phase_timeout      = 1'b0;
`endif

   // Abort only when the expected ACK edge has not arrived; a late ACK wins the tie
   assign abort = phase_timeout &
                  (((state_q == REQ_HI) & ~ack_s) | ((state_q == REQ_LO) & ack_s));

   // FSM state register
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (!fifo_empty) state_d = SETUP;
         SETUP:  state_d = REQ_HI;
         REQ_HI: if (ack_s) state_d = REQ_LO;
                 else if (abort) state_d = IDLE;
         REQ_LO: if (!ack_s || abort) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: pop/latch in IDLE, REQ registered from the next state to stay glitch-free
   always_comb begin
      pop    = (state_q == IDLE) & ~fifo_empty;
      req_d  = (state_d == REQ_HI);
      addr_d = pop ? fifo_rd_data : addr_q;
   end

   // Output registers and sticky flags
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         req_q     <= 1'b0;
         addr_q    <= '0;
         drop_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         req_q     <= req_d;
         addr_q    <= addr_d;
         drop_q    <= drop_q | drop_set;
         timeout_q <= timeout_q | abort;
      end
   end

   assign bus.AEROUT_REQ     = req_q;
   assign bus.AEROUT_ADDR    = addr_q;
   assign bus.AEROUT_FULL    = fifo_full;
   assign bus.AEROUT_EMPTY   = fifo_empty & (state_q == IDLE);
   assign bus.AEROUT_DROP    = drop_q;
   assign bus.AEROUT_TIMEOUT = timeout_q;

endmodule

// File: tb/tb_aer_out_transmitter.sv
// Self-checking bench for aer_out_transmitter: scoreboard of pushed words checked on each REQ
// rise, with a behavioural receiver acking after a programmable delay.
module tb_aer_out_transmitter;
   import aer_out_transmitter_pkg::*;

   logic CLK;
   logic RSTN;

   aer_out_transmitter_if bus ();

   aer_out_transmitter #(
      .FIFO_DEPTH  (8),
      .ACK_TIMEOUT (16)
   ) dut (
      .CLK  (CLK),
      .RSTN (RSTN),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int unsigned n_checks;
   int unsigned n_pass;
   int unsigned rise_cnt;
   bit          stall;
   int unsigned ack_dly;
   logic [AER_OUT_WIDTH-1:0] sb [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic push(input logic [1:0] v, input logic [9:0] a, input bit exp_acc);
      bus.CORE_EVENT_IN    = 1'b1;
      bus.CORE_EVENT_VIRTS = v;
      bus.CORE_EVENT_ADDR  = a;
      if (exp_acc) sb.push_back({v, a});
      @(negedge CLK);
      bus.CORE_EVENT_IN = 1'b0;
   endtask

   task automatic wait_req(input logic val, input int budget, input string tag);
      int n = 0;
      while (bus.AEROUT_REQ !== val && n < budget) begin
         @(negedge CLK);
         n++;
      end
      if (bus.AEROUT_REQ !== val) check(tag, 32'(bus.AEROUT_REQ), 32'(val));
   endtask

   task automatic wait_drain(input int budget, input string tag);
      int n = 0;
      while ((sb.size() != 0 || bus.AEROUT_EMPTY !== 1'b1) && n < budget) begin
         @(negedge CLK);
         n++;
      end
      check({tag, "_empty"}, 32'(bus.AEROUT_EMPTY), 32'd1);
      check({tag, "_sb_left"}, sb.size(), 32'd0);
   endtask

   task automatic do_reset();
      RSTN = 1'b0;
      sb.delete();
      repeat (2) @(negedge CLK);
      RSTN = 1'b1;
      repeat (4) @(negedge CLK);
   endtask

   initial begin
      int unsigned rises0;
      int          len;
      n_checks = 0;
      n_pass   = 0;
      rise_cnt = 0;
      stall    = 1'b0;
      ack_dly  = 3;
      RSTN     = 1'b0;
      bus.CORE_EVENT_IN    = 1'b0;
      bus.CORE_EVENT_VIRTS = '0;
      bus.CORE_EVENT_ADDR  = '0;
      bus.SPI_AER_OUT_EN   = 1'b1;
      bus.AEROUT_ACK       = 1'b0;

      fork
         // Receiver: raise ACK ack_dly negedges after REQ, drop it once REQ falls
         begin : receiver
            int unsigned dly = 0;
            forever begin
               @(negedge CLK);
               if (bus.AEROUT_REQ && !bus.AEROUT_ACK && !stall) begin
                  if (dly >= ack_dly) begin
                     bus.AEROUT_ACK = 1'b1;
                     dly = 0;
                  end else begin
                     dly++;
                  end
               end else if (!bus.AEROUT_REQ && bus.AEROUT_ACK) begin
                  bus.AEROUT_ACK = 1'b0;
               end
            end
         end
         // Monitor: each REQ rise must carry the oldest expected word, held until REQ falls
         begin : monitor
            logic                     prev = 1'b0;
            logic [AER_OUT_WIDTH-1:0] cur  = '0;
            logic [AER_OUT_WIDTH-1:0] exp_w;
            forever begin
               @(negedge CLK);
               if (RSTN) begin
                  if (bus.AEROUT_REQ && !prev) begin
                     rise_cnt++;
                     if (sb.size() == 0) begin
                        check("unexpected_req", 32'd1, 32'd0);
                     end else begin
                        exp_w = sb.pop_front();
                        check("sb_word", 32'(bus.AEROUT_ADDR), 32'(exp_w));
                     end
                     cur = bus.AEROUT_ADDR;
                  end else if (!bus.AEROUT_REQ && prev) begin
                     check("addr_stable", 32'(bus.AEROUT_ADDR), 32'(cur));
                  end
               end
               prev = bus.AEROUT_REQ;
            end
         end
      join_none

      // Reset values
      repeat (2) @(negedge CLK);
      check("rst_req", 32'(bus.AEROUT_REQ), 32'd0);
      check("rst_addr", 32'(bus.AEROUT_ADDR), 32'd0);
      check("rst_full", 32'(bus.AEROUT_FULL), 32'd0);
      check("rst_empty", 32'(bus.AEROUT_EMPTY), 32'd1);
      check("rst_drop", 32'(bus.AEROUT_DROP), 32'd0);
      check("rst_timeout", 32'(bus.AEROUT_TIMEOUT), 32'd0);
      RSTN = 1'b1;
      repeat (4) @(negedge CLK);

      // 1: single event, REQ two edges after the push edge
      push(2'b01, 10'h05A, 1'b1);
      check("t1_req_n1", 32'(bus.AEROUT_REQ), 32'd0);
      @(negedge CLK);
      check("t1_req_n2", 32'(bus.AEROUT_REQ), 32'd0);
      @(negedge CLK);
      check("t1_req_n3", 32'(bus.AEROUT_REQ), 32'd1);
      check("t1_addr", 32'(bus.AEROUT_ADDR), 32'h45A);
      wait_drain(100, "t1");

      // 4 + 2: fill behind a stalled handshake, coincident push/pop, then overflow
      stall = 1'b1;
      push(2'b11, 10'h3FF, 1'b1);
      wait_req(1'b1, 20, "t4_first_req");
      for (int i = 0; i < 8; i++) push(2'(i), 10'h100 + 10'(i), 1'b1);
      check("t2_full", 32'(bus.AEROUT_FULL), 32'd1);
      check("t2_drop_pre", 32'(bus.AEROUT_DROP), 32'd0);
      stall = 1'b0;
      wait_req(1'b0, 40, "t4_req_fall");
      repeat (3) @(negedge CLK);
      push(2'b10, 10'h2AA, 1'b1);
      check("t4_full", 32'(bus.AEROUT_FULL), 32'd1);
      check("t4_drop", 32'(bus.AEROUT_DROP), 32'd0);
      push(2'b01, 10'h155, 1'b0);
      check("t2_drop", 32'(bus.AEROUT_DROP), 32'd1);
      wait_drain(1000, "t2");

      // 3: disabled output discards silently
      do_reset();
      bus.SPI_AER_OUT_EN = 1'b0;
      repeat (4) @(negedge CLK);
      rises0 = rise_cnt;
      for (int i = 0; i < 3; i++) push(2'b00, 10'h010 + 10'(i), 1'b0);
      repeat (20) @(negedge CLK);
      check("t3_no_req", rise_cnt, rises0);
      check("t3_drop", 32'(bus.AEROUT_DROP), 32'd0);
      check("t3_empty", 32'(bus.AEROUT_EMPTY), 32'd1);
      bus.SPI_AER_OUT_EN = 1'b1;
      repeat (4) @(negedge CLK);

      // 5: reset mid-handshake
      stall = 1'b1;
      push(2'b01, 10'h0C3, 1'b1);
      push(2'b10, 10'h0C4, 1'b1);
      wait_req(1'b1, 20, "t5_req");
      #2 RSTN = 1'b0;
      #1;
      check("t5_req_async", 32'(bus.AEROUT_REQ), 32'd0);
      check("t5_addr_rst", 32'(bus.AEROUT_ADDR), 32'd0);
      check("t5_empty_rst", 32'(bus.AEROUT_EMPTY), 32'd1);
      sb.delete();
      stall = 1'b0;
      repeat (2) @(negedge CLK);
      RSTN = 1'b1;
      rises0 = rise_cnt;
      repeat (30) @(negedge CLK);
      check("t5_no_residual", rise_cnt, rises0);
      check("t5_empty", 32'(bus.AEROUT_EMPTY), 32'd1);

`ifdef AEROUT_TIMEOUT_EN
      // 6: ACK never comes, handshake aborts after ACK_TIMEOUT cycles
      stall = 1'b1;
      push(2'b11, 10'h077, 1'b1);
      wait_req(1'b1, 20, "t6_req");
      len = 1;
      @(negedge CLK);
      while (bus.AEROUT_REQ === 1'b1 && len < 60) begin
         len++;
         @(negedge CLK);
      end
      check("t6_req_len_ok", 32'(len >= 16 && len <= 18), 32'd1);
      check("t6_timeout", 32'(bus.AEROUT_TIMEOUT), 32'd1);
      stall = 1'b0;
      repeat (4) @(negedge CLK);
      push(2'b00, 10'h078, 1'b1);
      wait_drain(100, "t6");
`else
      len = 0;
      check("timeout_tied", 32'(bus.AEROUT_TIMEOUT) + 32'(len), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
